// File: rtl/can_pkg.sv
// Shared CAN constants and the transmit state type, used by both TX and RX paths.
package can_pkg;
  localparam int unsigned CAN_FRAME_W   = 69;
  localparam int unsigned CAN_CRC_W     = 15;
  localparam logic [14:0] CAN_CRC_POLY  = 15'h4599;
  localparam int unsigned CAN_STUFF_RUN = 5;
  localparam int unsigned CAN_EOF_LEN   = 7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FRAME,
    TX_CRC,
    TX_CRC_DLM,
    TX_ACK_SLOT,
    TX_ACK_DLM,
    TX_EOF
  } tx_state_t;
endpackage

// File: rtl/can_crc15.sv
// Bit-serial CAN CRC-15 accumulator; one data bit folded in per enabled cycle.
module can_crc15
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 din,
  output logic [CAN_CRC_W-1:0] crc
);
  logic [CAN_CRC_W-1:0] r_crc;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_crc <= '0;
    end else if (en) begin
      r_crc <= {r_crc[CAN_CRC_W-2:0], 1'b0} ^ ((din ^ r_crc[CAN_CRC_W-1]) ? CAN_CRC_POLY : '0);
    end
  end

  assign crc = r_crc;
endmodule

// File: rtl/can_tx_serializer.sv
// CAN transmit bit engine: stuffs and serializes frame + CRC-15, then delimiters,
// ACK slot check and EOF, one bus bit per bit_tick.
module can_tx_serializer
  import can_pkg::*;
#(
  parameter int unsigned FRAME_W   = CAN_FRAME_W,
  parameter int unsigned STUFF_RUN = CAN_STUFF_RUN,
  parameter int unsigned EOF_LEN   = CAN_EOF_LEN
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_tick,
  input  logic               tx_enable,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               rxd,
  output logic               txd,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               ack_error
);
  localparam logic [6:0] LP_LAST_DATA = 7'(FRAME_W - 1);
  localparam logic [6:0] LP_LAST_CRC  = 7'(CAN_CRC_W - 1);
  localparam logic [6:0] LP_CRC_DONE  = 7'(CAN_CRC_W);
  localparam logic [6:0] LP_LAST_EOF  = 7'(EOF_LEN - 1);
  localparam logic [2:0] LP_RUN       = 3'(STUFF_RUN);

  tx_state_t            r_state, w_state;
  logic [FRAME_W-1:0]   r_shift, w_shift;
  logic [6:0]           r_bit_cnt, w_bit_cnt;
  logic [2:0]           r_run_cnt, w_run_cnt;
  logic                 r_last, w_last;
  logic                 r_txd, w_txd;
  logic                 r_done, w_done;
  logic                 r_ack_err, w_ack_err;
  logic                 w_crc_clear, w_crc_en, w_bit;
  logic [3:0]           w_crc_idx;
  logic [CAN_CRC_W-1:0] w_crc;

  can_crc15 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (w_crc_clear),
    .en    (w_crc_en),
    .din   (r_shift[FRAME_W-1]),
    .crc   (w_crc)
  );

  assign w_crc_idx = 4'd14 - r_bit_cnt[3:0];

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_bit_cnt   = r_bit_cnt;
    w_run_cnt   = r_run_cnt;
    w_last      = r_last;
    w_txd       = r_txd;
    w_done      = 1'b0;
    w_ack_err   = 1'b0;
    w_crc_clear = 1'b0;
    w_crc_en    = 1'b0;
    w_bit       = 1'b1;
    if (r_state == TX_IDLE) begin
      w_txd = 1'b1;
      if (tx_enable) begin
        w_shift     = frame_data;
        w_crc_clear = 1'b1;
        w_run_cnt   = '0;
        w_bit_cnt   = '0;
        w_state     = TX_FRAME;
      end
    end else if (!tx_enable) begin
      w_state = TX_IDLE;
      w_txd   = 1'b1;
    end else if (bit_tick) begin
      unique case (r_state)
        TX_FRAME, TX_CRC: begin
          if (r_run_cnt == LP_RUN) begin
            w_txd     = ~r_last;
            w_last    = ~r_last;
            w_run_cnt = 3'd1;
            if (r_state == TX_CRC && r_bit_cnt == LP_CRC_DONE) begin
              w_state   = TX_CRC_DLM;
              w_bit_cnt = '0;
            end
          end else begin
            w_bit     = (r_state == TX_FRAME) ? r_shift[FRAME_W-1] : w_crc[w_crc_idx];
            w_txd     = w_bit;
            w_last    = w_bit;
            w_run_cnt = (w_bit == r_last && r_run_cnt != '0) ? r_run_cnt + 3'd1 : 3'd1;
            w_bit_cnt = r_bit_cnt + 7'd1;
            if (r_state == TX_FRAME) begin
              w_shift  = {r_shift[FRAME_W-2:0], 1'b0};
              w_crc_en = 1'b1;
              if (r_bit_cnt == LP_LAST_DATA) begin
                w_state   = TX_CRC;
                w_bit_cnt = '0;
              end
            end else if (r_bit_cnt == LP_LAST_CRC && w_run_cnt != LP_RUN) begin
              w_state   = TX_CRC_DLM;
              w_bit_cnt = '0;
            end
            // a trailing run after the last CRC bit parks at bit_cnt==15 for one stuff bit
          end
        end
        TX_CRC_DLM: begin
          w_txd   = 1'b1;
          w_state = TX_ACK_SLOT;
        end
        TX_ACK_SLOT: begin
          w_txd     = 1'b1;
          w_ack_err = rxd;
          w_state   = TX_ACK_DLM;
        end
        TX_ACK_DLM: begin
          w_txd     = 1'b1;
          w_bit_cnt = '0;
          w_state   = TX_EOF;
        end
        TX_EOF: begin
          w_txd     = 1'b1;
          w_bit_cnt = r_bit_cnt + 7'd1;
          if (r_bit_cnt == LP_LAST_EOF) begin
            w_bit_cnt = '0;
            w_done    = 1'b1;
            w_state   = TX_IDLE;
          end
        end
        default: w_state = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= TX_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_run_cnt <= '0;
      r_last    <= 1'b1;
      r_txd     <= 1'b1;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_bit_cnt <= w_bit_cnt;
      r_run_cnt <= w_run_cnt;
      r_last    <= w_last;
      r_txd     <= w_txd;
      r_done    <= w_done;
      r_ack_err <= w_ack_err;
    end
  end

  assign txd       = r_txd;
  assign tx_busy   = (r_state != TX_IDLE);
  assign tx_done   = r_done;
  assign ack_error = r_ack_err;
endmodule
